// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared state encodings, note codes and tone periods for the melody sequencer
package melody_pkg;

  localparam int DUR_W   = 2;
  localparam int CODE_W  = 3;
  localparam int ENTRY_W = DUR_W + CODE_W;

  typedef struct packed {
    logic [DUR_W-1:0]  dur;
    logic [CODE_W-1:0] code;
  } rom_entry_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [CODE_W-1:0] REST = 3'd0;
  localparam logic [CODE_W-1:0] N_DO = 3'd1;
  localparam logic [CODE_W-1:0] N_RE = 3'd2;
  localparam logic [CODE_W-1:0] N_MI = 3'd3;
  localparam logic [CODE_W-1:0] N_FA = 3'd4;
  localparam logic [CODE_W-1:0] N_SO = 3'd5;
  localparam logic [CODE_W-1:0] N_LA = 3'd6;
  localparam logic [CODE_W-1:0] N_XI = 3'd7;

  // Tone periods in 50 MHz system clocks
  localparam logic [17:0] P_DO = 18'd190839;
  localparam logic [17:0] P_RE = 18'd170068;
  localparam logic [17:0] P_MI = 18'd151515;
  localparam logic [17:0] P_FA = 18'd143266;
  localparam logic [17:0] P_SO = 18'd127551;
  localparam logic [17:0] P_LA = 18'd113636;
  localparam logic [17:0] P_XI = 18'd101214;

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - 16x5 melody ROM with registered read, one cycle latency
module melody_rom
  import melody_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         addr,
  output logic [ENTRY_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      case (addr)
        4'd0:    data <= {2'd0, N_DO};
        4'd1:    data <= {2'd1, REST};
        4'd2:    data <= {2'd0, N_XI};
        4'd3:    data <= {2'd0, N_DO};
        4'd4:    data <= {2'd0, N_SO};
        4'd5:    data <= {2'd0, N_SO};
        4'd6:    data <= {2'd0, N_LA};
        4'd7:    data <= {2'd0, N_LA};
        4'd8:    data <= {2'd1, N_SO};
        4'd9:    data <= {2'd0, N_FA};
        4'd10:   data <= {2'd0, N_FA};
        4'd11:   data <= {2'd0, N_MI};
        4'd12:   data <= {2'd0, N_MI};
        4'd13:   data <= {2'd0, N_RE};
        4'd14:   data <= {2'd0, N_RE};
        default: data <= {2'd3, N_DO};
      endcase
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps through the melody ROM and presents tone period/duty per note
module melody_sequencer
  import melody_pkg::*;
#(
  parameter logic [24:0] BEAT_COUNT_MAX = 25'd24_999_999,
  // Held at counter width so the 2.5M-clock default gap is representable
  parameter logic [24:0] GAP_CYCLES     = 25'd2_500_000,
  parameter logic [4:0]  MELODY_LEN     = 5'd16
) (
  input  logic        system_clock,
  input  logic        system_reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [17:0] note_period,
  output logic [16:0] note_duty,
  output logic        note_valid,
  output logic [3:0]  step_index,
  output logic        busy,
  output logic        done
);

  logic [1:0]         state;
  logic [24:0]        beat_cnt;
  logic [DUR_W-1:0]   beat_num;
  logic [24:0]        gap_cnt;
  logic [ENTRY_W-1:0] rom_q;
  rom_entry_t         entry;
  logic [17:0]        table_period;
  logic               play_end;
  logic               gap_end;
  logic               step_end;
  logic               last_step;

  melody_rom u_rom (
    .clk   (system_clock),
    .rst_n (system_reset_n),
    .addr  (step_index),
    .data  (rom_q)
  );

  assign entry = rom_entry_t'(rom_q);

  always_comb begin
    table_period = 18'd0;
    case (entry.code)
      N_DO:    table_period = P_DO;
      N_RE:    table_period = P_RE;
      N_MI:    table_period = P_MI;
      N_FA:    table_period = P_FA;
      N_SO:    table_period = P_SO;
      N_LA:    table_period = P_LA;
      N_XI:    table_period = P_XI;
      default: table_period = 18'd0;
    endcase
  end

  assign note_period = (state == ST_PLAY) ? table_period : 18'd0;
  assign note_duty   = note_period[17:1];
  assign note_valid  = (state == ST_PLAY) && (entry.code != REST);
  assign busy        = (state != ST_IDLE);

  assign play_end  = (state == ST_PLAY) && (beat_cnt == BEAT_COUNT_MAX) && (beat_num == entry.dur);
  assign gap_end   = (state == ST_GAP) && (gap_cnt == GAP_CYCLES - 25'd1);
  assign step_end  = (GAP_CYCLES == 25'd0) ? play_end : gap_end;
  assign last_step = ({1'b0, step_index} >= MELODY_LEN - 5'd1);

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state      <= ST_IDLE;
      step_index <= 4'd0;
      beat_cnt   <= 25'd0;
      beat_num   <= '0;
      gap_cnt    <= 25'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= ST_IDLE;
        step_index <= 4'd0;
        beat_cnt   <= 25'd0;
        beat_num   <= '0;
        gap_cnt    <= 25'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state      <= ST_LOAD;
              step_index <= 4'd0;
            end
          end
          ST_LOAD: begin
            state    <= ST_PLAY;
            beat_cnt <= 25'd0;
            beat_num <= '0;
          end
          ST_PLAY: begin
            if (beat_cnt == BEAT_COUNT_MAX) begin
              beat_cnt <= 25'd0;
              if (beat_num == entry.dur) begin
                beat_num <= '0;
                gap_cnt  <= 25'd0;
                if (GAP_CYCLES != 25'd0) state <= ST_GAP;
              end else begin
                beat_num <= beat_num + 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 25'd1;
            end
          end
          default: begin
            gap_cnt <= gap_end ? 25'd0 : gap_cnt + 25'd1;
          end
        endcase

        // Step advance overrides the per-state updates above
        if (step_end) begin
          if (!last_step) begin
            step_index <= step_index + 4'd1;
            state      <= ST_LOAD;
          end else if (loop_en) begin
            step_index <= 4'd0;
            state      <= ST_LOAD;
          end else begin
            step_index <= 4'd0;
            state      <= ST_IDLE;
            done       <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - randomized self-checking bench against a per-cycle melody model
module tb_melody_sequencer;

  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int LEN  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic start_ng = 1'b0, stop_ng = 1'b0, loop_en_ng = 1'b0;

  logic [17:0] note_period, note_period_ng;
  logic [16:0] note_duty, note_duty_ng;
  logic        note_valid, note_valid_ng;
  logic [3:0]  step_index, step_index_ng;
  logic        busy, busy_ng, done, done_ng;

  int vectors = 0;
  int miscompares = 0;

  int periods [8] = '{0, 190839, 170068, 151515, 143266, 127551, 113636, 101214};
  int rom_dur [3] = '{0, 1, 0};
  int rom_code[3] = '{1, 0, 7};

  logic [41:0] exp_q[$];
  logic [41:0] obs;
  logic [41:0] obs_ng;

  always #5 clk = ~clk;

  melody_sequencer #(
    .BEAT_COUNT_MAX (25'd9),
    .GAP_CYCLES     (25'd2),
    .MELODY_LEN     (5'd3)
  ) dut (
    .system_clock   (clk),
    .system_reset_n (rst_n),
    .start          (start),
    .stop           (stop),
    .loop_en        (loop_en),
    .note_period    (note_period),
    .note_duty      (note_duty),
    .note_valid     (note_valid),
    .step_index     (step_index),
    .busy           (busy),
    .done           (done)
  );

  melody_sequencer #(
    .BEAT_COUNT_MAX (25'd9),
    .GAP_CYCLES     (25'd0),
    .MELODY_LEN     (5'd3)
  ) dut_ng (
    .system_clock   (clk),
    .system_reset_n (rst_n),
    .start          (start_ng),
    .stop           (stop_ng),
    .loop_en        (loop_en_ng),
    .note_period    (note_period_ng),
    .note_duty      (note_duty_ng),
    .note_valid     (note_valid_ng),
    .step_index     (step_index_ng),
    .busy           (busy_ng),
    .done           (done_ng)
  );

  assign obs    = {note_period, note_duty, note_valid, step_index, busy, done};
  assign obs_ng = {note_period_ng, note_duty_ng, note_valid_ng, step_index_ng, busy_ng, done_ng};

  function automatic logic [41:0] pack(input int period, input bit valid, input int step,
                                       input bit bsy, input bit dn);
    logic [17:0] p;
    logic [16:0] d;
    logic [3:0]  s;
    p = 18'(period);
    d = 17'(period / 2);
    s = 4'(step);
    return {p, d, valid, s, bsy, dn};
  endfunction

  // Expected cycle-by-cycle outputs, starting with the cycle after the start edge
  function automatic void build(input int gap, input bit looping);
    exp_q.delete();
    for (int s = 0; s < LEN; s++) begin
      exp_q.push_back(pack(0, 1'b0, s, 1'b1, 1'b0));
      for (int c = 0; c < (rom_dur[s] + 1) * BEAT; c++)
        exp_q.push_back(pack(periods[rom_code[s]], rom_code[s] != 0, s, 1'b1, 1'b0));
      for (int c = 0; c < gap; c++)
        exp_q.push_back(pack(0, 1'b0, s, 1'b1, 1'b0));
    end
    if (looping) begin
      exp_q.push_back(pack(0, 1'b0, 0, 1'b1, 1'b0));
      for (int c = 0; c < (rom_dur[0] + 1) * BEAT; c++)
        exp_q.push_back(pack(periods[rom_code[0]], 1'b1, 0, 1'b1, 1'b0));
    end else begin
      exp_q.push_back(pack(0, 1'b0, 0, 1'b0, 1'b1));
    end
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== 42'd0) begin
      miscompares++;
      $display("FAIL reset_outputs obs=%h exp=0", obs);
    end
    vectors++;
    if (obs_ng !== 42'd0) begin
      miscompares++;
      $display("FAIL reset_outputs_ng obs=%h exp=0", obs_ng);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_no_start cyc %0d busy=%b done=%b exp 0/0", i, busy, done);
      end
    end
  endtask

  task automatic test_single_play;
    build(GAP, 1'b0);
    loop_en = 1'b0;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (exp_q[i]) begin
      vectors++;
      if (obs !== exp_q[i]) begin
        miscompares++;
        $display("FAIL single_play cyc %0d obs=%h exp=%h", i, obs, exp_q[i]);
      end
      @(negedge clk);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_play_after busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_loop;
    build(GAP, 1'b1);
    loop_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (exp_q[i]) begin
      vectors++;
      if (obs !== exp_q[i]) begin
        miscompares++;
        $display("FAIL loop cyc %0d obs=%h exp=%h", i, obs, exp_q[i]);
      end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop_en = 1'b0;
    vectors++;
    if (obs !== 42'd0) begin
      miscompares++;
      $display("FAIL loop_stop obs=%h exp=0", obs);
    end
  endtask

  task automatic test_abort;
    int k;
    build(GAP, 1'b0);
    // Rest step occupies model cycles 14..33
    k = $urandom_range(14, 33);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= k; i++) begin
      vectors++;
      if (obs !== exp_q[i]) begin
        miscompares++;
        $display("FAIL abort_pre cyc %0d obs=%h exp=%h", i, obs, exp_q[i]);
      end
      if (i == k) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs !== 42'd0) begin
        miscompares++;
        $display("FAIL abort_idle cyc %0d obs=%h exp=0", i, obs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    build(GAP, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (exp_q[i]) begin
      vectors++;
      if (obs !== exp_q[i]) begin
        miscompares++;
        $display("FAIL start_busy cyc %0d obs=%h exp=%h", i, obs, exp_q[i]);
      end
      start = (i < exp_q.size() - 1) && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_busy_after busy=%b exp=0", busy);
    end
  endtask

  task automatic test_start_stop_same;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs !== 42'd0) begin
        miscompares++;
        $display("FAIL start_stop_same cyc %0d obs=%h exp=0", i, obs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset;
    int n;
    n = $urandom_range(1, 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (n) @(negedge clk);
    vectors++;
    if (note_valid !== 1'b1 || note_period !== 18'd190839) begin
      miscompares++;
      $display("FAIL async_pre valid=%b period=%0d exp 1/190839", note_valid, note_period);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 42'd0) begin
      miscompares++;
      $display("FAIL async_reset obs=%h exp=0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_after busy=%b exp=0", busy);
    end
  endtask

  task automatic test_gapless;
    build(0, 1'b0);
    start_ng = 1'b1;
    @(negedge clk);
    start_ng = 1'b0;
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_ng !== exp_q[i]) begin
        miscompares++;
        $display("FAIL gapless cyc %0d obs=%h exp=%h", i, obs_ng, exp_q[i]);
      end
      @(negedge clk);
    end
    vectors++;
    if (busy_ng !== 1'b0) begin
      miscompares++;
      $display("FAIL gapless_after busy=%b exp=0", busy_ng);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_play();
    test_loop();
    test_abort();
    test_back_to_back();
    test_start_stop_same();
    test_async_reset();
    test_gapless();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
